// File: rtl/flap_input_ctrl_if.sv
// Button and game-flow signals exchanged between the playfield and the flap input controller.
interface flap_input_ctrl_if;
  logic BtnRaw;
  logic Tick;
  logic GameOver;
  logic BtnPress;
  logic Start;
  logic Ack;
  logic BtnLevel;

  modport master (
    output BtnRaw, Tick, GameOver,
    input  BtnPress, Start, Ack, BtnLevel
  );

  modport slave (
    input  BtnRaw, Tick, GameOver,
    output BtnPress, Start, Ack, BtnLevel
  );
endinterface

// File: rtl/flap_input_ctrl.sv
// Cleans the raw flap button into Start / Ack / BtnPress strobes for the flight physics block.
//   state  | meaning
//   S_IDLE | waiting for a press to start a game
//   S_PLAY | game running; presses become BtnPress on Tick, subject to cooldown
//   S_OVER | game lost; a press acknowledges and returns to S_IDLE
module flap_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int COOLDOWN_TICKS  = 4
) (
  input logic              Clk,
  input logic              reset,
  flap_input_ctrl_if.slave bus
);

  localparam int CD_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0]  CD_INIT = CD_W'(COOLDOWN_TICKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              btn_level_q, btn_level_d;
  logic              level_prev_q, level_prev_d;
  logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic              pending_q, pending_d;
  logic [CD_W-1:0]   cool_q, cool_d;

  logic ev;
  logic press;
  logic start;
  logic ack;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_level_q  <= 1'b0;
      level_prev_q <= 1'b0;
      db_cnt_q     <= '0;
      pending_q    <= 1'b0;
      cool_q       <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_level_q  <= btn_level_d;
      level_prev_q <= level_prev_d;
      db_cnt_q     <= db_cnt_d;
      pending_q    <= pending_d;
      cool_q       <= cool_d;
    end
  end

  // Level only moves after the synchronised input has differed for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    sync1_d      = bus.BtnRaw;
    sync2_d      = sync1_q;
    level_prev_d = btn_level_q;
    btn_level_d  = btn_level_q;
    db_cnt_d     = '0;
    if (sync2_q != btn_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign ev = btn_level_q & ~level_prev_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cool_d    = cool_q;
    press     = 1'b0;
    start     = 1'b0;
    ack       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ev) begin
          start     = 1'b1;
          state_d   = S_PLAY;
          pending_d = 1'b0;
          cool_d    = '0;
        end
      end
      S_PLAY: begin
        // GameOver wins over a flap landing on the same Tick.
        if (bus.GameOver) begin
          state_d   = S_OVER;
          pending_d = 1'b0;
          cool_d    = '0;
        end else if (bus.Tick) begin
          if ((pending_q | ev) && (cool_q == '0)) begin
            press     = 1'b1;
            pending_d = 1'b0;
            cool_d    = CD_INIT;
          end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
          end
        end else if (ev && (cool_q == '0)) begin
          pending_d = 1'b1;
        end
      end
      S_OVER: begin
        if (ev) begin
          ack     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.BtnPress = press & ~reset;
  assign bus.Start    = start & ~reset;
  assign bus.Ack      = ack & ~reset;
  assign bus.BtnLevel = btn_level_q;

endmodule

// File: tb/tb_flap_input_ctrl.sv
// Directed bench for flap_input_ctrl: debounce, start/ack flow, Tick alignment, cooldown and reset.
module tb_flap_input_ctrl;
  logic Clk;
  logic reset;

  flap_input_ctrl_if bus ();

  flap_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .COOLDOWN_TICKS (2)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int phase     = 0;
  int start_cnt = 0;
  int ack_cnt   = 0;
  int press_cnt = 0;
  int bad_cnt   = 0;
  bit tick_en   = 1'b1;
  bit go_on_tick = 1'b0;
  bit lvl_seen  = 1'b0;
  int p0, s0, a0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: Tick follows a 10-cycle period (high on phase 9); outputs sampled on the falling edge.
  task automatic cycle();
    @(posedge Clk);
    #1;
    cyc++;
    phase = (phase == 9) ? 0 : phase + 1;
    bus.Tick = tick_en && (phase == 9);
    if (go_on_tick && bus.Tick) bus.GameOver = 1'b1;
    @(negedge Clk);
    if (bus.Start) start_cnt++;
    if (bus.Ack) ack_cnt++;
    if (bus.BtnPress) begin
      press_cnt++;
      if (!bus.Tick) bad_cnt++;
    end
    if (int'(bus.Start) + int'(bus.Ack) + int'(bus.BtnPress) > 1) bad_cnt++;
    if (bus.BtnLevel) lvl_seen = 1'b1;
  endtask

  task automatic wait_phase(input int p);
    do cycle(); while (phase != p);
  endtask

  // Press from phase 0 for 5 cycles: the press event lands on phase 6, release settles by phase 1.
  task automatic press_in_period();
    wait_phase(0);
    bus.BtnRaw = 1'b1;
    repeat (5) cycle();
    bus.BtnRaw = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.BtnRaw   = 1'b1;
    bus.Tick     = 1'b0;
    bus.GameOver = 1'b0;

    // Reset held with the button down
    repeat (3) cycle();
    chk("rst_outs", int'({bus.BtnPress, bus.Start, bus.Ack, bus.BtnLevel}), 0);
    chk("rst_no_strobe", start_cnt + ack_cnt + press_cnt, 0);
    reset = 1'b0;
    repeat (5) cycle();
    chk("lvl_before", int'(bus.BtnLevel), 0);
    cycle();
    chk("lvl_rise", int'(bus.BtnLevel), 1);
    chk("start_on_rise", int'(bus.Start), 1);
    repeat (4) cycle();
    chk("start_once", start_cnt, 1);
    bus.BtnRaw = 1'b0;
    repeat (8) cycle();

    // Back to IDLE, then bounce
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    start_cnt = 0; ack_cnt = 0; press_cnt = 0; lvl_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.BtnRaw = (i % 2 == 0);
      repeat (2) cycle();
    end
    bus.BtnRaw = 1'b0;
    repeat (8) cycle();
    chk("bounce_level", int'(lvl_seen), 0);
    chk("bounce_strobes", start_cnt + ack_cnt + press_cnt, 0);
    bus.BtnRaw = 1'b1;
    repeat (8) cycle();
    chk("bounce_then_start", start_cnt, 1);
    bus.BtnRaw = 1'b0;
    repeat (8) cycle();
    chk("play_no_flap", press_cnt, 0);

    // Flap alignment: event on phase 3, flap on the phase-9 Tick
    wait_phase(7);
    p0 = press_cnt;
    bus.BtnRaw = 1'b1;
    repeat (6) cycle();
    chk("align_early", press_cnt, p0);
    repeat (6) cycle();
    chk("align_tick", int'(bus.BtnPress), 1);
    chk("align_cnt", press_cnt, p0 + 1);
    cycle();
    chk("align_width", int'(bus.BtnPress), 0);
    bus.BtnRaw = 1'b0;
    repeat (30) cycle();
    chk("align_single", press_cnt, p0 + 1);

    // Three presses with no Tick in between collapse into one flap
    tick_en = 1'b0;
    p0 = press_cnt;
    repeat (3) begin
      bus.BtnRaw = 1'b1;
      repeat (6) cycle();
      bus.BtnRaw = 1'b0;
      repeat (6) cycle();
    end
    chk("multi_held", press_cnt, p0);
    tick_en = 1'b1;
    repeat (12) cycle();
    chk("multi_single", press_cnt, p0 + 1);
    repeat (30) cycle();

    // Cooldown of two Ticks after a flap
    press_in_period();
    wait_phase(9);
    chk("cd_flap", int'(bus.BtnPress), 1);
    press_in_period();
    wait_phase(9);
    chk("cd_tick1", int'(bus.BtnPress), 0);
    press_in_period();
    wait_phase(9);
    chk("cd_tick2", int'(bus.BtnPress), 0);
    press_in_period();
    wait_phase(9);
    chk("cd_tick3", int'(bus.BtnPress), 1);
    repeat (25) cycle();

    // GameOver on the same cycle as a pending Tick
    p0 = press_cnt;
    press_in_period();
    go_on_tick = 1'b1;
    wait_phase(9);
    chk("go_level", int'(bus.GameOver), 1);
    chk("go_no_flap", int'(bus.BtnPress), 0);
    go_on_tick = 1'b0;
    repeat (10) cycle();
    chk("go_cnt", press_cnt, p0);
    a0 = ack_cnt;
    s0 = start_cnt;
    press_in_period();
    wait_phase(9);
    chk("over_ack", ack_cnt, a0 + 1);
    chk("over_no_start", start_cnt, s0);
    chk("over_no_flap", press_cnt, p0);
    bus.GameOver = 1'b0;
    press_in_period();
    wait_phase(9);
    chk("idle_start", start_cnt, s0 + 1);

    // Reset while a press is pending in PLAY
    repeat (10) cycle();
    p0 = press_cnt;
    s0 = start_cnt;
    press_in_period();
    cycle();
    reset = 1'b1;
    cycle();
    chk("mid_rst_outs", int'({bus.BtnPress, bus.Start, bus.Ack, bus.BtnLevel}), 0);
    reset = 1'b0;
    repeat (30) cycle();
    chk("mid_rst_no_flap", press_cnt, p0);
    chk("mid_rst_no_start", start_cnt, s0);
    press_in_period();
    wait_phase(9);
    chk("mid_rst_idle", start_cnt, s0 + 1);
    chk("mid_rst_idle_no_flap", press_cnt, p0);

    chk("strobe_rules", bad_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
